// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave that turns a command byte plus data byte(s) into single-cycle register-file strobes.
// Optional build macro SPI_AUTOINC_EN: keep streaming bytes at addr+1 after byte1 instead of ignoring them.
module spi_slave_regif #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic       i_ck,
  input  logic       i_rstn,
  input  logic       i_spi_clk,
  input  logic       i_spi_csn,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_spi_miso_oe,
  output logic [3:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_wr,
  output logic       o_reg_rd,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy,
  output logic       o_frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DATA, S_DONE, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q, vld_sync_q;
  logic                   sclk_s, csn_s, mosi_s, vld_s;
  logic                   sclk_rise, sclk_fall;
  logic [7:0]             byte_in;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rw_q, rw_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       armed_q, armed_d;
  logic       wr_pend_q, wr_pend_d;
  logic       rd_pend_q, rd_pend_d;
  logic       reg_wr_q, reg_wr_d;
  logic       reg_rd_q, reg_rd_d;
  logic       ld_q, ld_d;
  logic       tx_act_q, tx_act_d;
  logic       frame_err_q, frame_err_d;

  // The valid chain marks when the synchronisers hold real samples rather than reset values,
  // so a frame already in progress at reset release is never mistaken for a new CSn fall.
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      vld_sync_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain shifts by one stage per clock.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_clk};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0],  i_spi_csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
      vld_sync_q  <= {vld_sync_q[SYNC_STAGES-2:0],  1'b1};
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign vld_s     = vld_sync_q[SYNC_STAGES-1];
  assign sclk_rise = vld_s &  sclk_s & ~sclk_prev_q;
  assign sclk_fall = vld_s & ~sclk_s &  sclk_prev_q;
  assign byte_in   = {rx_sr_q, mosi_s};

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    tx_act_d    = tx_act_q;
    sclk_prev_d = vld_s ? sclk_s : sclk_prev_q;
    armed_d     = vld_s & csn_s;
    wr_pend_d   = 1'b0;
    rd_pend_d   = 1'b0;
    reg_wr_d    = wr_pend_q;
    reg_rd_d    = rd_pend_q;
    ld_d        = reg_rd_q;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (vld_s && armed_q && !csn_s) begin
          state_d   = S_CMD;
          bit_cnt_d = 3'd0;
          tx_act_d  = 1'b0;
        end
      end
      S_CMD: begin
        if (sclk_rise) begin
          rx_sr_d   = byte_in[6:0];
          bit_cnt_d = 3'(bit_cnt_q + 3'd1);
          if (bit_cnt_q == 3'd7) begin
            if (byte_in[6:4] != 3'b000) begin
              state_d = S_IGNORE;
            end else begin
              state_d   = S_DATA;
              addr_d    = byte_in[3:0];
              rw_d      = byte_in[7];
              rd_pend_d = byte_in[7];
            end
          end
        end
      end
      S_DATA: begin
        // The fall that opens a byte presents the freshly loaded MSB, so only mid-byte falls shift.
        if (sclk_fall && tx_act_q && bit_cnt_q != 3'd0) begin
          tx_sr_d = {tx_sr_q[6:0], IDLE_MISO};
        end
        if (sclk_rise) begin
          rx_sr_d   = byte_in[6:0];
          bit_cnt_d = 3'(bit_cnt_q + 3'd1);
          if (bit_cnt_q == 3'd7) begin
            if (!rw_q) begin
              wdata_d   = byte_in;
              wr_pend_d = 1'b1;
            end
`ifdef SPI_AUTOINC_EN
            if (rw_q) begin
              addr_d    = addr_q + 4'd1;
              rd_pend_d = 1'b1;
            end
`else
            state_d  = S_DONE;
            tx_act_d = 1'b0;
`endif
          end
        end
      end
      default: ;
    endcase

`ifdef SPI_AUTOINC_EN
    // Writes advance the address only after the strobe so addr/wdata stay stable during it.
    if (reg_wr_q) begin
      addr_d = addr_q + 4'd1;
    end
`endif

    if (ld_q && state_q == S_DATA) begin
      tx_sr_d  = i_reg_rdata;
      tx_act_d = 1'b1;
    end

    if (vld_s && csn_s && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      tx_act_d  = 1'b0;
      if ((state_q == S_CMD || state_q == S_DATA) && bit_cnt_q != 3'd0) begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      ld_q        <= 1'b0;
      tx_act_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      sclk_prev_q <= sclk_prev_d;
      armed_q     <= armed_d;
      wr_pend_q   <= wr_pend_d;
      rd_pend_q   <= rd_pend_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      ld_q        <= ld_d;
      tx_act_q    <= tx_act_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_spi_miso    = tx_act_q ? tx_sr_q[7] : IDLE_MISO;
  assign o_spi_miso_oe = vld_s & ~csn_s;
  assign o_reg_addr    = addr_q;
  assign o_reg_wdata   = wdata_q;
  assign o_reg_wr      = reg_wr_q;
  assign o_reg_rd      = reg_rd_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_frame_err   = frame_err_q;

endmodule
